// File: rtl/ov5640_sccb_pkg.sv
// ov5640_sccb_pkg: shared FSM states and ID-byte constants for the SCCB slave
package ov5640_sccb_pkg;
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;
  localparam logic ID_WR = 1'b0;
  localparam logic ID_RD = 1'b1;
  localparam logic [6:0] DEF_DEV_ID = 7'h3C;
endpackage

// File: rtl/ov5640_sccb_slave_det.sv
// ov5640_sccb_slave_det: synchronizes the SCCB lines and flags clock edges and START/STOP
module ov5640_sccb_slave_det (
  input  logic sysclk,
  input  logic rst_n,
  input  logic cmos_sclk,
  input  logic sdat_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);
  // [1:0] form the synchronizer; [2] holds the previous synchronized value
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], cmos_sclk};
      sda_q <= {sda_q[1:0], sdat_i};
    end
  end
  assign sda      = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/ov5640_sccb_slave.sv
// ov5640_sccb_slave: SCCB register-file slave; OV5640_SCCB_SLAVE_ACK_EN drives I2C-style ACKs
module ov5640_sccb_slave
  import ov5640_sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID = DEF_DEV_ID,
  parameter int MEM_AW = 8
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        cmos_sclk,
  input  logic        sdat_i,
  output logic        sdat_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);
`ifdef OV5640_SCCB_SLAVE_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif
  logic scl_rise, scl_fall, start, stop, sda;
  state_t state;
  logic [2:0] cnt;
  logic [7:0] sr, tx, rx;
  logic [15:0] ptr, nxt;
  logic [7:0] mem [2**MEM_AW];
  logic last, rx_ack, ninth, we;
  ov5640_sccb_slave_det det (
    .sysclk(sysclk), .rst_n(rst_n), .cmos_sclk(cmos_sclk), .sdat_i(sdat_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda(sda)
  );
  assign rx     = {sr[6:0], sda};
  assign nxt    = ptr + 16'd1;
  assign last   = cnt == 3'd7;
  assign rx_ack = state == ID_ACK || state == ADDR_H_ACK || state == ADDR_L_ACK || state == WDATA_ACK;
  assign ninth  = rx_ack || state == RDATA_MACK;
  assign we     = rst_n && !start && !stop && scl_rise && state == WDATA && last;
  always_ff @(posedge sysclk) if (we) mem[ptr[MEM_AW-1:0]] <= rx;
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      tx       <= '0;
      ptr      <= '0;
      sdat_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (start) begin
        state   <= ID;
        cnt     <= '0;
        sdat_oe <= 1'b0;
      end else if (stop) begin
        state   <= IDLE;
        cnt     <= '0;
        sdat_oe <= 1'b0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        cnt <= ninth ? 3'd0 : cnt + 3'd1;
        sr  <= rx_ack ? sr : rx;
        case (state)
          ID: if (last) begin
            state <= rx[7:1] == DEV_ID ? ID_ACK : IDLE;
            busy  <= rx[7:1] == DEV_ID;
          end
          ID_ACK: begin
            state <= sr[0] == ID_RD ? RDATA : ADDR_H;
            tx    <= mem[ptr[MEM_AW-1:0]];
          end
          ADDR_H: if (last) begin
            ptr[15:8] <= rx;
            state     <= ADDR_H_ACK;
          end
          ADDR_H_ACK: state <= ADDR_L;
          ADDR_L: if (last) begin
            ptr[7:0] <= rx;
            state    <= ADDR_L_ACK;
          end
          ADDR_L_ACK: state <= WDATA;
          WDATA: if (last) begin
            wr_valid <= 1'b1;
            wr_addr  <= ptr;
            wr_data  <= rx;
            ptr      <= nxt;
            state    <= WDATA_ACK;
          end
          WDATA_ACK: state <= WDATA;
          RDATA: begin
            tx <= {tx[6:0], 1'b0};
            if (last) state <= RDATA_MACK;
          end
          // master ACK continues the burst; NACK idles with busy held until STOP
          RDATA_MACK: if (!sda) begin
            ptr   <= nxt;
            tx    <= mem[nxt[MEM_AW-1:0]];
            state <= RDATA;
          end else state <= IDLE;
          default: ;
        endcase
      end else if (scl_fall) sdat_oe <= rx_ack ? ACK_DRIVE : state == RDATA ? ~tx[7] : 1'b0;
    end
  end
endmodule

// File: tb/tb_ov5640_sccb_slave.sv
// tb_ov5640_sccb_slave: directed and randomized SCCB transfers against a register-file model
module tb_ov5640_sccb_slave;
`ifdef OV5640_SCCB_SLAVE_ACK_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif
  localparam int Q = 50;
  logic sysclk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic sdat_i, sdat_oe, wr_valid, busy;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  int total = 0, bad = 0, wr_cnt = 0, oe_cnt = 0;
  logic [23:0] wlog [0:1023];
  logic [7:0] mm [0:255];
  assign sdat_i = sda_m & ~sdat_oe;
  ov5640_sccb_slave dut (
    .sysclk(sysclk), .rst_n(rst_n), .cmos_sclk(scl), .sdat_i(sdat_i), .sdat_oe(sdat_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always #5 sysclk = ~sysclk;
  always @(negedge sysclk) begin
    if (wr_valid) begin
      wlog[wr_cnt % 1024] = {wr_addr, wr_data};
      wr_cnt = wr_cnt + 1;
    end
    if (sdat_oe) oe_cnt = oe_cnt + 1;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask
  task automatic bit_out(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask
  task automatic byte_out(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = sdat_oe; #Q; scl = 1'b0; #Q;
  endtask
  task automatic byte_in(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; d[i] = sdat_i; #Q; scl = 1'b0; #Q;
    end
    sda_m = nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask
  initial begin
    logic a;
    logic [7:0] r, d;
    logic [15:0] base, ad;
    int w0, o0, len;
    repeat (4) @(posedge sysclk);
    #1;
    check("rst_oe", sdat_oe, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge sysclk);
    // single write
    w0 = wr_cnt; o0 = oe_cnt;
    bus_start();
    byte_out(8'h78, a); check("ack_id", a, ACK_EXP);
    byte_out(8'hAA, a); check("ack_ah", a, ACK_EXP);
    byte_out(8'h56, a); check("ack_al", a, ACK_EXP);
    check("busy_mid", busy, 1);
    byte_out(8'hBB, a); check("ack_wd", a, ACK_EXP);
    bus_stop();
    check("wr_count", wr_cnt - w0, 1);
    check("wr_entry", wlog[w0 % 1024], {16'hAA56, 8'hBB});
    check("busy_stop", busy, 0);
    check("oe_any", oe_cnt > o0, ACK_EXP);
    // two-phase pointer set then read with NACK
    w0 = wr_cnt;
    bus_start();
    byte_out(8'h78, a); byte_out(8'hAA, a); byte_out(8'h56, a);
    bus_stop();
    check("twophase_nowr", wr_cnt - w0, 0);
    bus_start();
    byte_out(8'h79, a);
    byte_in(1'b1, r);
    check("read_bb", r, 8'hBB);
    check("nack_release", sdat_oe, 0);
    bus_stop();
    check("read_busy", busy, 0);
    // foreign device ID
    w0 = wr_cnt; o0 = oe_cnt;
    bus_start();
    byte_out(8'h60, a);
    check("foreign_busy", busy, 0);
    byte_out(8'h12, a);
    bus_stop();
    check("foreign_oe", oe_cnt - o0, 0);
    check("foreign_wr", wr_cnt - w0, 0);
    // STOP mid ADDR_L, then a clean write
    bus_start();
    byte_out(8'h78, a); byte_out(8'h12, a);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    bus_stop();
    check("partial_wr", wr_cnt - w0, 0);
    check("partial_busy", busy, 0);
    bus_start();
    byte_out(8'h78, a); byte_out(8'hAA, a); byte_out(8'h56, a); byte_out(8'hCC, a);
    bus_stop();
    check("after_partial_cnt", wr_cnt - w0, 1);
    check("after_partial", wlog[w0 % 1024], {16'hAA56, 8'hCC});
    // burst across a low-byte carry
    w0 = wr_cnt;
    bus_start();
    byte_out(8'h78, a); byte_out(8'h00, a); byte_out(8'hFF, a);
    byte_out(8'h11, a); byte_out(8'h22, a);
    bus_stop();
    check("burst_cnt", wr_cnt - w0, 2);
    check("burst_0", wlog[w0 % 1024], {16'h00FF, 8'h11});
    check("burst_1", wlog[(w0 + 1) % 1024], {16'h0100, 8'h22});
    // random bursts with readback against the register-file model
    for (int it = 0; it < 8; it++) begin
      base = it == 0 ? 16'hFFFE : 16'($urandom);
      len = it == 0 ? 4 : int'($urandom_range(1, 4));
      w0 = wr_cnt;
      bus_start();
      byte_out(8'h78, a); byte_out(base[15:8], a); byte_out(base[7:0], a);
      for (int j = 0; j < len; j++) begin
        d = 8'($urandom);
        ad = base + 16'(j);
        mm[ad[7:0]] = d;
        byte_out(d, a);
        @(negedge sysclk);
        check("rnd_wr", wlog[(w0 + j) % 1024], {ad, d});
      end
      bus_stop();
      check("rnd_cnt", wr_cnt - w0, len);
      bus_start();
      byte_out(8'h78, a); byte_out(base[15:8], a); byte_out(base[7:0], a);
      bus_stop();
      bus_start();
      byte_out(8'h79, a);
      for (int j = 0; j < len; j++) begin
        ad = base + 16'(j);
        byte_in(j == len - 1, r);
        check("rnd_rd", r, mm[ad[7:0]]);
      end
      bus_stop();
    end
    // reset while the slave holds the line low
    bus_start();
    byte_out(8'h78, a); byte_out(8'h00, a); byte_out(8'h10, a); byte_out(8'h00, a);
    bus_stop();
    bus_start();
    byte_out(8'h78, a); byte_out(8'h00, a); byte_out(8'h10, a);
    bus_stop();
    bus_start();
    byte_out(8'h79, a);
    for (int k = 0; k < 200 && !sdat_oe; k++) @(posedge sysclk);
    check("rd_drive", sdat_oe, 1);
    @(negedge sysclk) rst_n = 1'b0;
    @(posedge sysclk);
    #1;
    check("rst_release", sdat_oe, 0);
    check("rst_busy2", busy, 0);
    repeat (3) @(posedge sysclk);
    rst_n = 1'b1;
    bus_stop();
    w0 = wr_cnt;
    bus_start();
    byte_out(8'h78, a); byte_out(8'h12, a); byte_out(8'h34, a); byte_out(8'h56, a);
    bus_stop();
    check("post_rst_cnt", wr_cnt - w0, 1);
    check("post_rst_wr", wlog[w0 % 1024], {16'h1234, 8'h56});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ov5640_sccb_slave.md
OV5640_SCCB_SLAVE -- requirements
Module: ov5640_sccb_slave

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'h3C: 7-bit device ID, so the write ID byte is 0x78 and the read ID byte is 0x79.
REQ-002 SHALL have parameter MEM_AW, default 8: register-file address width (depth 2**MEM_AW bytes).
REQ-003 SHALL have port sysclk, input, 1: system clock, at least 8x the SCCB clock rate.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port cmos_sclk, input, 1: SCCB clock from the master.
REQ-006 SHALL have port sdat_i, input, 1: resolved SCCB data line.
REQ-007 SHALL have port sdat_oe, output, 1: 1 = pull the data line low; 0 = release it.
REQ-008 SHALL have port wr_valid, output, 1: one-cycle pulse per accepted data byte.
REQ-009 SHALL have port wr_addr, output, 16: sub-address of the accepted byte.
REQ-010 SHALL have port wr_data, output, 8: accepted data byte.
REQ-011 SHALL have port busy, output, 1: high from an addressed START until STOP.

Function
REQ-012 SHALL pass cmos_sclk and sdat_i through 2-flop synchronizers, then edge-detect them; all decisions are made on synchronized signals.
REQ-013 SHALL detect START (sdat falls while sclk is high) and STOP (sdat rises while sclk is high) in every state; START has priority and restarts at ID, STOP returns to IDLE.
REQ-014 SHALL sample data on sclk rising edges, MSB first, and change sdat_oe only on sclk falling edges.
REQ-015 SHALL implement states IDLE, ID, ID_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
REQ-016 ID byte: bits[7:1] != DEV_ID -> IDLE with no acknowledge; bit0=0 -> ADDR_H; bit0=1 -> RDATA, loading mem[ptr].
REQ-017 After ADDR_L_ACK, ptr SHALL equal {ADDR_H, ADDR_L}; the internal memory SHALL be indexed by ptr[MEM_AW-1:0].
REQ-018 Each completed WDATA byte SHALL write the memory, pulse wr_valid for 1 sysclk on the 8th-bit rising edge plus synchronizer delay (at most 4 sysclk), then increment ptr, wrapping at 16 bits.
REQ-019 A 2-phase write (ID plus address, then STOP) SHALL set ptr only, with no wr_valid.
REQ-020 RDATA SHALL drive sdat_oe = ~bit, releasing the line for 1s; in RDATA_MACK it SHALL sample the master: 0 -> increment ptr and send the next byte, 1 (NACK) -> release the line and wait for STOP.
REQ-021 STOP or START received mid-byte SHALL discard the partial byte, with no memory write.
REQ-022 sdat_oe SHALL be 0 whenever the state is not an ACK-driving state or RDATA.

Reset
REQ-023 On rst_n=0 at a sysclk edge: state=IDLE, sdat_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, ptr=0, synchronizers initialised to 1.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset asserted mid-transfer SHALL release the line on the next sysclk.

Configuration
REQ-026 With macro OV5640_SCCB_SLAVE_ACK_EN defined, the block SHALL drive sdat_oe=1 during ID_ACK, ADDR_H_ACK, ADDR_L_ACK and WDATA_ACK (I2C-style ACK).
REQ-027 Without OV5640_SCCB_SLAVE_ACK_EN, the 9th bit SHALL be a pure SCCB don't-care: sdat_oe stays 0 and the FSM advances identically.

Structure
REQ-028 Package ov5640_sccb_pkg SHALL hold the state enum, the ID read/write bit constants and the default DEV_ID.
REQ-029 Sub-module ov5640_sccb_slave_det SHALL contain the synchronizers, the sclk rise/fall detectors and the START/STOP detectors.

Verification
REQ-030 Write 0x78, 0xAA, 0x56, 0xBB -> one wr_valid with wr_addr=0xAA56 and wr_data=0xBB; with ACK_EN, sdat_oe=1 on all four 9th bits.
REQ-031 After REQ-030, send 0x78, 0xAA, 0x56, STOP, then START, 0x79, master NACK -> the line carries 0xBB MSB first, then the block returns to IDLE.
REQ-032 Write ID 0x60 -> sdat_oe never asserts, wr_valid never pulses, busy stays 0 after the ID.
REQ-033 STOP after 4 bits of ADDR_L -> no wr_valid, state=IDLE; a following valid write behaves as in REQ-030.
REQ-034 Burst write 0x78, 0x00, 0xFF, 0x11, 0x22 -> wr_addr 0x00FF then 0x0100.
REQ-035 Reset mid-RDATA while driving low -> sdat_oe=0 one sysclk later; REQ-030 with the macro undefined -> sdat_oe stays 0 throughout.
